// File: rtl/pu_output_collector_pkg.sv
// +----------------------------------------------------------------------------+
// | pu_output_collector_pkg : shared widths, latency and FSM encodings          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package pu_output_collector_pkg;

  localparam int PU_DATA_W = 5;
  localparam int PU_LAT    = 3;
  localparam int PU_N_OUT  = 8;
  localparam int PU_IDX_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } pu_state_e;

endpackage

`default_nettype wire

// File: rtl/pu_output_collector_if.sv
// +----------------------------------------------------------------------------+
// | pu_output_collector_if : control, PU result and readback bundle             |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pu_output_collector_if
  import pu_output_collector_pkg::*;
#(
  parameter int DATA_W = PU_DATA_W,
  parameter int IDX_W  = PU_IDX_W
);

  logic              start;
  logic              issue;
  logic [DATA_W-1:0] pu_out;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] max_val;
  logic [IDX_W-1:0]  max_idx;
  logic [IDX_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              overflow_err;

  modport master (
    output start, issue, pu_out, rd_addr,
    input  busy, done, max_val, max_idx, rd_data, overflow_err
  );

  modport slave (
    input  start, issue, pu_out, rd_addr,
    output busy, done, max_val, max_idx, rd_data, overflow_err
  );

endinterface

`default_nettype wire

// File: rtl/pu_output_collector_valid_pipe.sv
// +----------------------------------------------------------------------------+
// | pu_output_collector_valid_pipe : clearable valid shift register             |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module pu_output_collector_valid_pipe #(
  parameter int DEPTH = 3
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clr,
  input  wire logic i_valid,
  output logic      o_valid
);

  logic [DEPTH-1:0] r_sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst || i_clr) r_sr <= '0;
        else              r_sr <= i_valid;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst || i_clr) r_sr <= '0;
        else              r_sr <= {r_sr[DEPTH-2:0], i_valid};
      end
    end
  endgenerate

  assign o_valid = r_sr[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/pu_output_collector.sv
// +----------------------------------------------------------------------------+
// | pu_output_collector : aligns PU results to issues, buffers frame, tracks max|
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module pu_output_collector
  import pu_output_collector_pkg::*;
#(
  parameter int DATA_W = PU_DATA_W,
  parameter int PU_LAT = pu_output_collector_pkg::PU_LAT,
  parameter int N_OUT  = PU_N_OUT,
  parameter int IDX_W  = PU_IDX_W
) (
  input  wire logic            clk,
  input  wire logic            rst,
  pu_output_collector_if.slave bus
);

  // One extra bit so the issue counter can represent N_OUT for overflow detection.
  localparam int               C_CNT_W  = IDX_W + 1;
  localparam logic [C_CNT_W-1:0] C_N_OUT  = C_CNT_W'(N_OUT);
  localparam logic [C_CNT_W-1:0] C_LAST   = C_CNT_W'(N_OUT - 1);
  localparam logic [C_CNT_W-1:0] C_ONE    = C_CNT_W'(1);

  pu_state_e           r_state;
  pu_state_e           w_state_nxt;
  logic [C_CNT_W-1:0]  r_iss_cnt;
  logic [C_CNT_W-1:0]  r_cap_cnt;
  logic [DATA_W-1:0]   r_max_val;
  logic [IDX_W-1:0]    r_max_idx;
  logic                r_done;
  logic                r_ovf;
  logic [DATA_W-1:0]   r_buf [N_OUT];

  logic w_collect;
  logic w_enter;
  logic w_issue_acc;
  logic w_overflow;
  logic w_tap;
  logic w_capture;
  logic w_last;

  assign w_collect   = (r_state == ST_COLLECT);
  assign w_enter     = bus.start && !w_collect;
  assign w_issue_acc = bus.issue && w_collect && (r_iss_cnt < C_N_OUT);
  assign w_overflow  = bus.issue && w_collect && (r_iss_cnt == C_N_OUT);
  assign w_capture   = w_tap && w_collect;
  assign w_last      = w_capture && (r_cap_cnt == C_LAST);

  pu_output_collector_valid_pipe #(
    .DEPTH (PU_LAT)
  ) u_valid_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_enter),
    .i_valid (w_issue_acc),
    .o_valid (w_tap)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (bus.start) w_state_nxt = ST_COLLECT;
      ST_COLLECT: if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE:    if (bus.start) w_state_nxt = ST_COLLECT;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_cnt <= '0;
      r_cap_cnt <= '0;
      r_max_val <= '0;
      r_max_idx <= '0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_enter) begin
        r_iss_cnt <= '0;
        r_cap_cnt <= '0;
        r_max_val <= '0;
        r_max_idx <= '0;
        r_ovf     <= 1'b0;
      end else begin
        if (w_issue_acc) r_iss_cnt <= r_iss_cnt + C_ONE;
        if (w_overflow)  r_ovf     <= 1'b1;
        if (w_capture) begin
          r_cap_cnt <= r_cap_cnt + C_ONE;
          // Strict compare keeps the earliest index on ties.
          if (bus.pu_out > r_max_val) begin
            r_max_val <= bus.pu_out;
            r_max_idx <= r_cap_cnt[IDX_W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_OUT; i++) r_buf[i] <= '0;
    end else if (w_capture) begin
      r_buf[r_cap_cnt[IDX_W-1:0]] <= bus.pu_out;
    end
  end

  assign bus.busy         = w_collect;
  assign bus.done         = r_done;
  assign bus.max_val      = r_max_val;
  assign bus.max_idx      = r_max_idx;
  assign bus.overflow_err = r_ovf;
  assign bus.rd_data      = ({1'b0, bus.rd_addr} < C_N_OUT) ? r_buf[bus.rd_addr] : '0;

endmodule

`default_nettype wire
